// File: rtl/mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder_pkg
// Description : Address map, STATUS bit positions and address decode helper.
// Revision    : 1.0
// ============================================================================
package mem_responder_pkg;

    localparam logic [15:0] c_addr_led    = 16'h8000;
    localparam logic [15:0] c_addr_timer  = 16'h8001;
    localparam logic [15:0] c_addr_txdata = 16'h8002;
    localparam logic [15:0] c_addr_status = 16'h8003;

    localparam int unsigned c_status_full_bit  = 0;
    localparam int unsigned c_status_empty_bit = 1;
    localparam int unsigned c_status_ovf_bit   = 2;

    typedef enum logic [2:0] {
        REGION_NONE   = 3'd0,
        REGION_RAM    = 3'd1,
        REGION_LED    = 3'd2,
        REGION_TIMER  = 3'd3,
        REGION_TXDATA = 3'd4,
        REGION_STATUS = 3'd5
    } region_e;

    function automatic region_e decode_addr(input logic [15:0] addr,
                                            input int unsigned ram_words);
        region_e r;
        r = REGION_NONE;
        if (32'(addr) < ram_words) begin
            r = REGION_RAM;
        end else begin
            case (addr)
                c_addr_led:    r = REGION_LED;
                c_addr_timer:  r = REGION_TIMER;
                c_addr_txdata: r = REGION_TXDATA;
                c_addr_status: r = REGION_STATUS;
                default:       r = REGION_NONE;
            endcase
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder_if
// Description : Core-side read/write bus plus UART TX byte stream.
// Revision    : 1.0
// ============================================================================
interface mem_responder_if;
    logic [15:0] i_read_addr;
    logic [15:0] o_read_data;
    logic [15:0] i_write_addr;
    logic [15:0] i_write_data;
    logic        i_write_strobe;
    logic [7:0]  o_leds;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready;

    modport master (
        output i_read_addr, i_write_addr, i_write_data, i_write_strobe, i_tx_ready,
        input  o_read_data, o_leds, o_tx_data, o_tx_valid
    );

    modport slave (
        input  i_read_addr, i_write_addr, i_write_data, i_write_strobe, i_tx_ready,
        output o_read_data, o_leds, o_tx_data, o_tx_valid
    );
endinterface
`default_nettype wire

// File: rtl/mem_responder_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tx_fifo
// Description : Byte FIFO feeding the UART; extra pointer bit tells full/empty.
// Revision    : 1.0
// ============================================================================
module tx_fifo #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  wire        clk_i,
    input  wire        rst_ni,
    input  wire        push_i,
    input  wire  [7:0] data_i,
    input  wire        pop_i,
    output logic [7:0] data_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    logic [7:0]     mem_q [FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    logic           w_do_push;
    logic           w_do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign data_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

    // A pop frees the slot in time for a push arriving on the same edge.
    assign w_do_pop  = pop_i & ~empty_o;
    assign w_do_push = push_i & (~full_o | w_do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_do_push) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
        if (w_do_pop)  rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= data_i;
    end

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Single-cycle memory-mapped RAM, LED, timer and UART TX FIFO.
// Revision    : 1.0
// ============================================================================
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned RAM_WORDS  = 8192,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input wire             i_clk,
    input wire             i_rst_n,
    mem_responder_if.slave bus
);

    localparam int unsigned RAM_AW = $clog2(RAM_WORDS);

    logic [15:0] ram_mem [RAM_WORDS];
    logic [15:0] ram_rd_q;

    region_e     rd_region_q;
    logic [15:0] reg_rd_q, reg_rd_d;
    logic [7:0]  led_q, led_d;
    logic [15:0] timer_q, timer_d;
    logic        ovf_q, ovf_d;

    region_e     w_rd_region;
    region_e     w_wr_region;
    logic        w_ram_we;
    logic        w_led_we;
    logic        w_tx_wr;
    logic        w_status_wr;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic        w_pop;
    logic        w_push;
    logic        w_ovf_set;
    logic [15:0] w_status;
    logic [7:0]  w_tx_data;

    assign w_rd_region = decode_addr(bus.i_read_addr, RAM_WORDS);
    assign w_wr_region = bus.i_write_strobe ? decode_addr(bus.i_write_addr, RAM_WORDS)
                                            : REGION_NONE;

    assign w_ram_we    = (w_wr_region == REGION_RAM);
    assign w_led_we    = (w_wr_region == REGION_LED);
    assign w_tx_wr     = (w_wr_region == REGION_TXDATA);
    assign w_status_wr = (w_wr_region == REGION_STATUS);

    assign w_pop     = ~w_fifo_empty & bus.i_tx_ready;
    assign w_push    = w_tx_wr & (~w_fifo_full | w_pop);
    assign w_ovf_set = w_tx_wr & w_fifo_full & ~w_pop;

    tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk_i   (i_clk),
        .rst_ni  (i_rst_n),
        .push_i  (w_push),
        .data_i  (bus.i_write_data[7:0]),
        .pop_i   (w_pop),
        .data_o  (w_tx_data),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty)
    );

    // Read-first block RAM; no reset so it maps onto a plain memory macro.
    always_ff @(posedge i_clk) begin
        if (w_ram_we) ram_mem[bus.i_write_addr[RAM_AW-1:0]] <= bus.i_write_data;
        ram_rd_q <= ram_mem[bus.i_read_addr[RAM_AW-1:0]];
    end

    always_comb begin
        w_status = '0;
        w_status[c_status_full_bit]  = w_fifo_full;
        w_status[c_status_empty_bit] = w_fifo_empty;
        w_status[c_status_ovf_bit]   = ovf_q;
    end

    always_comb begin
        led_d   = w_led_we ? bus.i_write_data[7:0] : led_q;
        timer_d = timer_q + 16'd1;
        // Set wins over a simultaneous clear.
        ovf_d   = w_ovf_set | (ovf_q & ~w_status_wr);
        case (w_rd_region)
            REGION_LED:    reg_rd_d = {8'h00, led_q};
            REGION_TIMER:  reg_rd_d = timer_q;
            REGION_STATUS: reg_rd_d = w_status;
            default:       reg_rd_d = 16'h0000;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_region_q <= REGION_NONE;
            reg_rd_q    <= 16'h0000;
            led_q       <= 8'h00;
            timer_q     <= 16'h0000;
            ovf_q       <= 1'b0;
        end else begin
            rd_region_q <= w_rd_region;
            reg_rd_q    <= reg_rd_d;
            led_q       <= led_d;
            timer_q     <= timer_d;
            ovf_q       <= ovf_d;
        end
    end

    // rd_region_q resets to REGION_NONE, so the output reads zero during reset.
    assign bus.o_read_data = (rd_region_q == REGION_RAM) ? ram_rd_q : reg_rd_q;
    assign bus.o_leds      = led_q;
    assign bus.o_tx_data   = w_tx_data;
    assign bus.o_tx_valid  = ~w_fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_responder
// Description : Directed plus randomized checks against a queue-based model.
// Revision    : 1.0
// ============================================================================
module tb_mem_responder;

    localparam int unsigned RAM_WORDS  = 8192;
    localparam int unsigned FIFO_DEPTH = 4;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;

    mem_responder_if bus();

    mem_responder #(
        .RAM_WORDS  (RAM_WORDS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    logic [15:0] m_ram   [RAM_WORDS];
    bit          m_known [RAM_WORDS];
    logic [7:0]  m_led;
    logic [15:0] m_timer;
    bit          m_ovf;
    logic [7:0]  m_q [$];

    int          vectors     = 0;
    int          miscompares = 0;
    logic [15:0] last_rd;
    bit          last_popped;
    logic [7:0]  last_pop_byte;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_read(input logic [15:0] a, output logic [15:0] v, output bit known);
        known = 1'b1;
        if (int'(a) < int'(RAM_WORDS)) begin
            known = m_known[int'(a)];
            v     = m_ram[int'(a)];
        end else if (a == 16'h8000) v = {8'h00, m_led};
        else if (a == 16'h8001)     v = m_timer;
        else if (a == 16'h8003)     v = {13'b0, m_ovf, m_q.size() == 0, m_q.size() == FIFO_DEPTH};
        else                        v = 16'h0000;
    endtask

    task automatic set_in(input logic [15:0] ra, input logic we, input logic [15:0] wa,
                          input logic [15:0] wd, input logic rdy);
        bus.i_read_addr    = ra;
        bus.i_write_strobe = we;
        bus.i_write_addr   = wa;
        bus.i_write_data   = wd;
        bus.i_tx_ready     = rdy;
    endtask

    // One clock edge: predict, advance the model, then compare after the edge.
    task automatic cycle();
        logic [15:0] exp_rd;
        bit          known;
        bit          pop;
        bit          pre_valid;
        logic [7:0]  pre_data;
        model_read(bus.i_read_addr, exp_rd, known);
        pre_valid = bus.o_tx_valid;
        pre_data  = bus.o_tx_data;
        pop = (m_q.size() != 0) && bus.i_tx_ready;
        if (pop) void'(m_q.pop_front());
        if (bus.i_write_strobe) begin
            if (int'(bus.i_write_addr) < int'(RAM_WORDS)) begin
                m_ram[int'(bus.i_write_addr)]   = bus.i_write_data;
                m_known[int'(bus.i_write_addr)] = 1'b1;
            end else if (bus.i_write_addr == 16'h8000) begin
                m_led = bus.i_write_data[7:0];
            end else if (bus.i_write_addr == 16'h8002) begin
                if (m_q.size() < FIFO_DEPTH) m_q.push_back(bus.i_write_data[7:0]);
                else                         m_ovf = 1'b1;
            end else if (bus.i_write_addr == 16'h8003) begin
                m_ovf = 1'b0;
            end
        end
        m_timer = m_timer + 16'd1;
        @(posedge i_clk);
        #1;
        last_rd       = bus.o_read_data;
        last_popped   = pre_valid && bus.i_tx_ready;
        last_pop_byte = pre_data;
        if (known) check("read_data", bus.o_read_data, exp_rd);
        check("tx_valid", 16'(bus.o_tx_valid), 16'(m_q.size() != 0));
        if (m_q.size() != 0) check("tx_data", 16'(bus.o_tx_data), 16'(m_q[0]));
        check("leds", 16'(bus.o_leds), 16'(m_led));
    endtask

    task automatic apply_reset();
        i_rst_n = 1'b0;
        #1;
        m_q.delete();
        m_led   = 8'h00;
        m_timer = 16'h0000;
        m_ovf   = 1'b0;
        check("rst_read_data", bus.o_read_data, 16'h0000);
        check("rst_tx_valid", 16'(bus.o_tx_valid), 16'h0000);
        check("rst_leds", 16'(bus.o_leds), 16'h0000);
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
    endtask

    function automatic logic [15:0] rand_addr();
        case ($urandom_range(0, 6))
            0, 1:    return 16'h0040 + 16'($urandom_range(0, 15));
            2, 3:    return 16'h8000 + 16'($urandom_range(0, 3));
            4:       return 16'($urandom_range(RAM_WORDS, 16'h7FFF));
            5:       return 16'h8004 + 16'($urandom_range(0, 16'h7FF0));
            default: return 16'($urandom_range(0, RAM_WORDS - 1));
        endcase
    endfunction

    initial begin
        logic [15:0] t10;
        logic [15:0] t15;
        logic [7:0]  got_bytes [$];
        int          guard;

        set_in(16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
        apply_reset();

        // Timer sampled at edges 10 and 15 after release, then after a full wrap.
        for (int e = 1; e <= 15; e++) begin
            set_in((e == 10 || e == 15) ? 16'h8001 : 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
            cycle();
            if (e == 10) t10 = last_rd;
            if (e == 15) t15 = last_rd;
        end
        check("timer_edge10", t10, 16'd9);
        check("timer_delta", t15 - t10, 16'd5);
        set_in(16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
        for (int k = 0; k < 65535; k++) cycle();
        set_in(16'h8001, 1'b0, 16'h0000, 16'h0000, 1'b0);
        cycle();
        check("timer_wrap", last_rd, t15);

        set_in(16'h0000, 1'b1, 16'h0010, 16'h1234, 1'b0);
        cycle();
        set_in(16'h0010, 1'b0, 16'h0000, 16'h0000, 1'b0);
        cycle();
        check("ram_wr_rd", last_rd, 16'h1234);

        set_in(16'h0000, 1'b1, 16'h0020, 16'h0001, 1'b0);
        cycle();
        set_in(16'h0020, 1'b1, 16'h0020, 16'hBEEF, 1'b0);
        cycle();
        check("ram_read_first", last_rd, 16'h0001);
        set_in(16'h0020, 1'b0, 16'h0000, 16'h0000, 1'b0);
        cycle();
        check("ram_after_write", last_rd, 16'hBEEF);

        set_in(16'h8000, 1'b1, 16'h8000, 16'h12A5, 1'b0);
        cycle();
        check("led_read_first", last_rd, 16'h0000);
        set_in(16'h8000, 1'b0, 16'h0000, 16'h0000, 1'b0);
        cycle();
        check("led_read", last_rd, 16'h00A5);

        // Fill past capacity with the UART stalled, then drain.
        for (int b = 0; b < 5; b++) begin
            set_in(16'h0000, 1'b1, 16'h8002, 16'h0041 + 16'(b), 1'b0);
            cycle();
        end
        set_in(16'h8003, 1'b0, 16'h0000, 16'h0000, 1'b0);
        cycle();
        check("status_full_ovf", last_rd, 16'h0005);
        for (int b = 0; b < 4; b++) begin
            set_in(16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1);
            cycle();
            check("drain_order", {7'b0, last_popped, last_pop_byte}, {8'h01, 8'h41 + 8'(b)});
        end
        set_in(16'h8003, 1'b0, 16'h0000, 16'h0000, 1'b1);
        cycle();
        check("status_empty_ovf", last_rd, 16'h0006);
        set_in(16'h0000, 1'b1, 16'h8003, 16'hFFFF, 1'b1);
        cycle();
        set_in(16'h8003, 1'b0, 16'h0000, 16'h0000, 1'b1);
        cycle();
        check("status_cleared", last_rd, 16'h0002);

        // Push into a full FIFO on the same edge as a pop.
        for (int b = 0; b < 4; b++) begin
            set_in(16'h0000, 1'b1, 16'h8002, 16'h0061 + 16'(b), 1'b0);
            cycle();
        end
        set_in(16'h0000, 1'b1, 16'h8002, 16'h0055, 1'b1);
        cycle();
        if (last_popped) got_bytes.push_back(last_pop_byte);
        set_in(16'h8003, 1'b0, 16'h0000, 16'h0000, 1'b1);
        cycle();
        if (last_popped) got_bytes.push_back(last_pop_byte);
        check("full_push_pop_ovf", 16'(last_rd[2]), 16'h0000);
        guard = 0;
        set_in(16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1);
        while (bus.o_tx_valid && guard < 10) begin
            cycle();
            if (last_popped) got_bytes.push_back(last_pop_byte);
            guard++;
        end
        check("drain_timeout", 16'(bus.o_tx_valid), 16'h0000);
        check("drain_count", 16'(got_bytes.size()), 16'd5);
        if (got_bytes.size() == 5) check("drain_last", 16'(got_bytes[4]), 16'h0055);

        for (int k = 0; k < 400; k++) begin
            set_in(rand_addr(), 1'($urandom_range(0, 1)), rand_addr(),
                   16'($urandom), 1'($urandom_range(0, 2) == 0));
            cycle();
        end

        // Reset while bytes are queued and the LED is lit.
        set_in(16'h0000, 1'b1, 16'h8000, 16'h00A5, 1'b0);
        cycle();
        for (int b = 0; b < 2; b++) begin
            set_in(16'h8000, 1'b1, 16'h8002, 16'h0070 + 16'(b), 1'b0);
            cycle();
        end
        set_in(16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
        apply_reset();
        set_in(16'h0010, 1'b0, 16'h0000, 16'h0000, 1'b0);
        cycle();
        check("ram_survives_reset", last_rd, 16'h1234);
        set_in(16'h8003, 1'b0, 16'h0000, 16'h0000, 1'b0);
        cycle();
        check("status_after_reset", last_rd, 16'h0002);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 8192, number of 16-bit RAM words mapped from address 0x0000 (power of two, max 16384).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, number of TX FIFO entries (power of two, minimum 2).
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 i_clk  in  1  sole clock, all state on rising edge.
REQ-005 i_rst_n  in  1  asynchronous active-low reset.
REQ-006 i_read_addr  in  16  word address driven combinationally by the core each cycle.
REQ-007 o_read_data  out  16  registered read data for the address presented the previous cycle.
REQ-008 i_write_addr  in  16  write word address.
REQ-009 i_write_data  in  16  write data.
REQ-010 i_write_strobe  in  1  write commits at the rising edge while high.
REQ-011 o_leds  out  8  LED register contents.
REQ-012 o_tx_data  out  8  byte at TX FIFO head.
REQ-013 o_tx_valid  out  1  TX FIFO non-empty.
REQ-014 i_tx_ready  in  1  downstream UART accepts head byte when high with o_tx_valid.

Function
REQ-015 Memory map SHALL be: 0x0000..RAM_WORDS-1 RAM; 0x8000 LED (RW, bits 7:0); 0x8001 TIMER (RO); 0x8002 TXDATA (WO, bits 7:0); 0x8003 STATUS (bit0 full, bit1 empty, bit2 overflow; write any value clears overflow); all other addresses unmapped.
REQ-016 Read latency SHALL be exactly 1 cycle: o_read_data after edge N equals content of i_read_addr sampled at edge N, every cycle, no stall or handshake.
REQ-017 Read and write to same RAM or LED address in same cycle SHALL return old data (read-first).
REQ-018 Unmapped reads, and reads of TXDATA, SHALL return 0x0000; LED reads return {8'h00, led}; STATUS reads return {13'b0, ovf, empty, full}.
REQ-019 Writes to unmapped addresses or TIMER SHALL be ignored; LED write takes i_write_data[7:0].
REQ-020 TIMER SHALL be a 16-bit free-running counter incrementing every cycle, wrapping 0xFFFF->0x0000; a read returns its value at the sampling edge.
REQ-021 TXDATA write SHALL push i_write_data[7:0] when FIFO not full, or when full and a pop occurs the same cycle.
REQ-022 TXDATA write to a full FIFO with no same-cycle pop SHALL drop the byte and set overflow (sticky).
REQ-023 Pop SHALL occur on any edge where o_tx_valid and i_tx_ready are both high; o_tx_data SHALL be stable while o_tx_valid high and i_tx_ready low.
REQ-024 Push and pop on an empty FIFO in the same cycle SHALL NOT pop (o_tx_valid was low); the byte appears next cycle.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH with one extra bit distinguishing full from empty.
REQ-026 Overflow set and clear in the same cycle SHALL leave overflow set.

Reset
REQ-027 On i_rst_n low SHALL asynchronously force: o_read_data 0x0000, LED 0x00, TIMER 0x0000, FIFO empty (o_tx_valid 0), overflow 0.
REQ-028 RAM contents SHALL NOT be cleared by reset; reset mid-FIFO-transfer discards all queued bytes.
REQ-029 Operation SHALL resume on the first rising edge after i_rst_n deasserts.

Structure
REQ-030 Address constants (LED, TIMER, TXDATA, STATUS addresses, STATUS bit indices) SHALL live in a shared include alongside the opcode constants.
REQ-031 The TX FIFO SHALL be a sub-module tx_fifo (push/pop/full/empty ports, parameter FIFO_DEPTH).
REQ-032 RAM SHALL be inferable as single-clock block RAM, one read and one write port.

Verification
REQ-033 Write 0x1234 to 0x0010, read 0x0010 next cycle -> o_read_data 0x1234 one cycle after address presented.
REQ-034 Same cycle: write 0xBEEF to 0x0020 (previously 0x0001) and read 0x0020 -> 0x0001; next read -> 0xBEEF.
REQ-035 Release reset, read 0x8001 at edges 10 and 15 -> values differ by exactly 5; hold 65536 cycles -> wraps.
REQ-036 i_tx_ready low, write 0x41..0x45 to 0x8002 -> STATUS 0x0005 (full+ovf), then i_tx_ready high -> bytes 0x41..0x44 in order, STATUS 0x0006, write 0x8003 -> 0x0002.
REQ-037 FIFO full, i_tx_ready high, write 0x55 same cycle -> pop and push both occur, no overflow, 0x55 eventually delivered.
REQ-038 Assert i_rst_n low mid-operation with 2 bytes queued and LED 0xA5 -> o_tx_valid 0, o_leds 0x00, o_read_data 0x0000 immediately; RAM 0x0010 still reads 0x1234.
